reg_scoreboard: RTL and testbench



---
 rtl/reg_pkg.sv | 17 +
 rtl/reg_scoreboard_sb_counter.sv | 41 ++++
 rtl/reg_scoreboard.sv | 142 ++++++++++++++
 tb/tb_reg_scoreboard.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_pkg
// Description : Shared register codes and scoreboard state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_pkg;
    localparam int NUM_REGS = 16;
    localparam int REG_RSP  = 4;

    typedef logic [3:0] regCode_t;

    typedef logic [0:0] sbState_t;
    localparam sbState_t RUN    = 1'b0;
    localparam sbState_t HALTED = 1'b1;
endpackage
`default_nettype wire

// File: rtl/reg_scoreboard_sb_counter.sv
`default_nettype none
// ============================================================================
// Module      : sb_counter
// Description : Saturating outstanding-writer counter for one register.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             full,
    output logic             underflow,
    output logic             overflow
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Simultaneous inc and dec cancel; clear has priority over both.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + 1'b1;
        end else if (dec && !inc && busy) begin
            count <= count - 1'b1;
        end
    end

    assign busy      = (count != '0);
    assign full      = (count == CNT_MAX);
    assign underflow = dec && !inc && !busy;
    assign overflow  = inc && !dec && full;
endmodule
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : GPR file with writeback commit, per-register writer scoreboard
//               and bypassed read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int               NUM_REGS = 16,
    parameter int               WIDTH    = 64,
    parameter int               CNT_W    = 2,
    parameter logic [WIDTH-1:0] RSP_INIT = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      resvValidIn,
    input  logic [3:0]                resvDestIn,
    input  logic                      resvDestValidIn,
    input  logic [3:0]                resvSpecialIn,
    input  logic                      resvSpecialValidIn,
    output logic                      resvReadyOut,
    input  logic                      wbValidIn,
    input  logic [3:0]                wbDestIn,
    input  logic [WIDTH-1:0]          wbDataIn,
    input  logic                      wbSpecialValidIn,
    input  logic [3:0]                wbSpecialIn,
    input  logic [WIDTH-1:0]          wbSpecialDataIn,
    input  logic                      wbKillIn,
    input  logic                      flushIn,
    input  logic [3:0]                rdAddr1In,
    input  logic [3:0]                rdAddr2In,
    output logic [WIDTH-1:0]          rdData1Out,
    output logic [WIDTH-1:0]          rdData2Out,
    output logic                      rdBusy1Out,
    output logic                      rdBusy2Out,
    output logic [NUM_REGS*WIDTH-1:0] regFileOut,
    output logic [NUM_REGS-1:0]       regInUseBitMapOut,
    output logic                      haltOut,
    output logic                      errorOut
);
    import reg_pkg::*;

    sbState_t            state;
    logic                error_flag;
    logic [WIDTH-1:0]    regs [NUM_REGS];
    logic [CNT_W-1:0]    cnt  [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic [NUM_REGS-1:0] busy_vec;
    logic [NUM_REGS-1:0] full_vec;
    logic [NUM_REGS-1:0] err_vec;
    logic                commit;
    logic                resv_accept;

    assign commit = wbValidIn && (state == RUN);

    // A commit on a full register does not free a slot in the same cycle.
    assign resvReadyOut = (state == RUN) && !flushIn
                        && !(resvDestValidIn    && full_vec[resvDestIn])
                        && !(resvSpecialValidIn && full_vec[resvSpecialIn]);
    assign resv_accept  = resvValidIn && resvReadyOut;

    generate
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
            logic under;
            logic over;

            assign inc_vec[r] = resv_accept
                && ((resvDestValidIn    && (resvDestIn    == regCode_t'(r)))
                 || (resvSpecialValidIn && (resvSpecialIn == regCode_t'(r))));
            assign dec_vec[r] = commit
                && ((wbDestIn == regCode_t'(r))
                 || (wbSpecialValidIn && (wbSpecialIn == regCode_t'(r))));

            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk       (clk),
                .reset     (reset),
                .inc       (inc_vec[r]),
                .dec       (dec_vec[r]),
                .clear     (flushIn),
                .count     (cnt[r]),
                .busy      (busy_vec[r]),
                .full      (full_vec[r]),
                .underflow (under),
                .overflow  (over)
            );

            assign err_vec[r]                   = under || over;
            assign regFileOut[r*WIDTH +: WIDTH] = regs[r];
        end
    endgenerate

    assign regInUseBitMapOut = busy_vec;

    // Special destination is written last so it wins when codes coincide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= (r == REG_RSP) ? RSP_INIT : '0;
            end
        end else if (commit) begin
            regs[wbDestIn] <= wbDataIn;
            if (wbSpecialValidIn) begin
                regs[wbSpecialIn] <= wbSpecialDataIn;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            error_flag <= 1'b0;
        end else begin
            if (commit && wbKillIn) begin
                state <= HALTED;
            end
            if (|err_vec) begin
                error_flag <= 1'b1;
            end
        end
    end

    assign haltOut  = (state == HALTED);
    assign errorOut = error_flag;

    function automatic logic [WIDTH-1:0] read_port(input regCode_t addr);
        if (commit && wbSpecialValidIn && (wbSpecialIn == addr)) begin
            return wbSpecialDataIn;
        end else if (commit && (wbDestIn == addr)) begin
            return wbDataIn;
        end
        return regs[addr];
    endfunction

    assign rdData1Out = read_port(rdAddr1In);
    assign rdData2Out = read_port(rdAddr2In);

    // Busy reflects the count as it will stand after this cycle's commit.
    assign rdBusy1Out = cnt[rdAddr1In] > {{(CNT_W-1){1'b0}}, dec_vec[rdAddr1In]};
    assign rdBusy2Out = cnt[rdAddr2In] > {{(CNT_W-1){1'b0}}, dec_vec[rdAddr2In]};
endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_scoreboard
// Description : Directed self-checking bench for reg_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;
    logic         clk = 1'b0;
    logic         reset;
    logic         resvValidIn, resvDestValidIn, resvSpecialValidIn;
    logic [3:0]   resvDestIn, resvSpecialIn;
    logic         resvReadyOut;
    logic         wbValidIn, wbSpecialValidIn, wbKillIn, flushIn;
    logic [3:0]   wbDestIn, wbSpecialIn;
    logic [63:0]  wbDataIn, wbSpecialDataIn;
    logic [3:0]   rdAddr1In, rdAddr2In;
    logic [63:0]  rdData1Out, rdData2Out;
    logic         rdBusy1Out, rdBusy2Out;
    logic [1023:0] regFileOut;
    logic [15:0]  regInUseBitMapOut;
    logic         haltOut, errorOut;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.RSP_INIT(64'h7FF0)) dut (
        .clk                (clk),
        .reset              (reset),
        .resvValidIn        (resvValidIn),
        .resvDestIn         (resvDestIn),
        .resvDestValidIn    (resvDestValidIn),
        .resvSpecialIn      (resvSpecialIn),
        .resvSpecialValidIn (resvSpecialValidIn),
        .resvReadyOut       (resvReadyOut),
        .wbValidIn          (wbValidIn),
        .wbDestIn           (wbDestIn),
        .wbDataIn           (wbDataIn),
        .wbSpecialValidIn   (wbSpecialValidIn),
        .wbSpecialIn        (wbSpecialIn),
        .wbSpecialDataIn    (wbSpecialDataIn),
        .wbKillIn           (wbKillIn),
        .flushIn            (flushIn),
        .rdAddr1In          (rdAddr1In),
        .rdAddr2In          (rdAddr2In),
        .rdData1Out         (rdData1Out),
        .rdData2Out         (rdData2Out),
        .rdBusy1Out         (rdBusy1Out),
        .rdBusy2Out         (rdBusy2Out),
        .regFileOut         (regFileOut),
        .regInUseBitMapOut  (regInUseBitMapOut),
        .haltOut            (haltOut),
        .errorOut           (errorOut)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        resvValidIn = 0; resvDestValidIn = 0; resvSpecialValidIn = 0;
        resvDestIn = 0; resvSpecialIn = 0;
        wbValidIn = 0; wbSpecialValidIn = 0; wbKillIn = 0; flushIn = 0;
        wbDestIn = 0; wbSpecialIn = 0; wbDataIn = 0; wbSpecialDataIn = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rdAddr1In = 0; rdAddr2In = 0;
        reset = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
        #1;
        chk("rst_rsp",    regFileOut[4*64 +: 64], 64'h7FF0);
        chk("rst_r0",     regFileOut[0 +: 64], 64'h0);
        chk("rst_r15",    regFileOut[15*64 +: 64], 64'h0);
        chk("rst_bitmap", {48'h0, regInUseBitMapOut}, 64'h0);
        chk("rst_ready",  {63'h0, resvReadyOut}, 64'h1);
        chk("rst_halt",   {62'h0, haltOut, errorOut}, 64'h0);

        // Reserve reg 3, idle one cycle, then commit with bypass
        tick();
        resvValidIn = 1; resvDestValidIn = 1; resvDestIn = 3;
        tick();
        idle(); rdAddr1In = 3;
        #1;
        chk("r3_bitmap", {48'h0, regInUseBitMapOut}, 64'h0008);
        chk("r3_busy",   {63'h0, rdBusy1Out}, 64'h1);
        tick();
        wbValidIn = 1; wbDestIn = 3; wbDataIn = 64'hDEAD;
        #1;
        chk("r3_bypass",      rdData1Out, 64'hDEAD);
        chk("r3_busy_commit", {63'h0, rdBusy1Out}, 64'h0);
        tick();
        idle();
        #1;
        chk("r3_regfile",   regFileOut[3*64 +: 64], 64'hDEAD);
        chk("r3_bitmap_clr", {48'h0, regInUseBitMapOut}, 64'h0);

        // Reg 5: two reservations, a net-zero cycle, then fill to 3
        resvValidIn = 1; resvDestValidIn = 1; resvDestIn = 5;
        #1 chk("r5_ready0", {63'h0, resvReadyOut}, 64'h1);
        tick();
        tick();
        wbValidIn = 1; wbDestIn = 5; wbDataIn = 64'h11;
        #1 chk("r5_ready_netzero", {63'h0, resvReadyOut}, 64'h1);
        tick();
        wbValidIn = 0;
        tick();
        #1 chk("r5_full_refuse", {63'h0, resvReadyOut}, 64'h0);
        wbValidIn = 1; wbDestIn = 5; wbDataIn = 64'h22;
        #1 chk("r5_commit_no_relief", {63'h0, resvReadyOut}, 64'h0);
        tick();
        wbValidIn = 0;
        #1 chk("r5_after_drain", {63'h0, resvReadyOut}, 64'h1);
        chk("r5_regfile", regFileOut[5*64 +: 64], 64'h22);
        idle();

        // Reg 2 reserved twice; commit with dest == special == 2
        resvValidIn = 1; resvDestValidIn = 1; resvDestIn = 2;
        tick();
        tick();
        idle();
        wbValidIn = 1; wbDestIn = 2; wbDataIn = 64'h1;
        wbSpecialValidIn = 1; wbSpecialIn = 2; wbSpecialDataIn = 64'h9;
        rdAddr2In = 2;
        #1 chk("r2_bypass_special", rdData2Out, 64'h9);
        tick();
        idle();
        #1;
        chk("r2_regfile",     regFileOut[2*64 +: 64], 64'h9);
        chk("r2_single_dec",  {48'h0, regInUseBitMapOut}, 64'h0024);
        chk("err_before",     {63'h0, errorOut}, 64'h0);
        wbValidIn = 1; wbDestIn = 7; wbDataIn = 64'h77;
        tick();
        idle();
        #1;
        chk("r7_underflow_err", {63'h0, errorOut}, 64'h1);
        chk("r7_regfile",       regFileOut[7*64 +: 64], 64'h77);
        chk("r7_bitmap",        {48'h0, regInUseBitMapOut}, 64'h0024);

        // Reserve reg 1, then flush alongside a commit of reg 1
        resvValidIn = 1; resvDestValidIn = 1; resvDestIn = 1;
        tick();
        idle();
        #1 chk("r1_bitmap", {48'h0, regInUseBitMapOut}, 64'h0026);
        flushIn = 1; wbValidIn = 1; wbDestIn = 1; wbDataIn = 64'h55;
        resvValidIn = 1; resvDestValidIn = 1; resvDestIn = 6;
        #1 chk("flush_refuse", {63'h0, resvReadyOut}, 64'h0);
        tick();
        idle();
        #1;
        chk("flush_bitmap",  {48'h0, regInUseBitMapOut}, 64'h0);
        chk("flush_r1",      regFileOut[1*64 +: 64], 64'h55);
        chk("flush_ready",   {63'h0, resvReadyOut}, 64'h1);

        // Kill commit halts; later commits are ignored
        wbValidIn = 1; wbKillIn = 1; wbDestIn = 8; wbDataIn = 64'hAB;
        tick();
        idle();
        #1;
        chk("kill_halt",    {63'h0, haltOut}, 64'h1);
        chk("kill_r8",      regFileOut[8*64 +: 64], 64'hAB);
        chk("halt_ready",   {63'h0, resvReadyOut}, 64'h0);
        wbValidIn = 1; wbDestIn = 8; wbDataIn = 64'hCD; rdAddr1In = 8;
        #1 chk("halt_no_bypass", rdData1Out, 64'hAB);
        tick();
        idle();
        #1 chk("halt_r8_kept", regFileOut[8*64 +: 64], 64'hAB);

        // Asynchronous reset mid-operation
        reset = 0;
        #1;
        chk("arst_halt",   {62'h0, haltOut, errorOut}, 64'h0);
        chk("arst_rsp",    regFileOut[4*64 +: 64], 64'h7FF0);
        chk("arst_r8",     regFileOut[8*64 +: 64], 64'h0);
        tick();
        reset = 1;
        #1 chk("arst_ready", {63'h0, resvReadyOut}, 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
